// File: rtl/ub_ctrl_pkg.sv
// Shared types and constants for the unified-buffer read controller.
// Lane 2 trails lane 1 by LANE2_SKEW cycles to form the array's diagonal skew.
package ub_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } ub_rd_state_t;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 9;
    localparam int LANE2_SKEW = 1;

endpackage

// File: rtl/ub_read_controller_lane_skew_reg.sv
// Data+valid delay line of configurable depth.
// Data is zeroed on entry whenever valid is low, so idle outputs read 0.
module lane_skew_reg #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= valid_in ? data_in : '0;
            valid_q[0] <= valid_in;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign data_out  = data_q[DEPTH-1];
    assign valid_out = valid_q[DEPTH-1];

endmodule

// File: rtl/ub_read_controller.sv
// Streams a 2xN operand out of the unified buffer into the two
// left-edge lanes of the systolic array, lane 2 skewed by one cycle.
module ub_read_controller #(
    parameter int UNIFIED_BUFFER_WIDTH = 50,
    parameter int ADDR_W               = 9,
    parameter int LEN_W                = 8,
    parameter int DATA_W               = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [LEN_W-1:0]  num_rows_in,
    input  logic              transpose_in,
    output logic              ub_rd_en_out,
    output logic [ADDR_W-1:0] ub_rd_addr_1_out,
    output logic [ADDR_W-1:0] ub_rd_addr_2_out,
    input  logic [DATA_W-1:0] ub_rd_data_1_in,
    input  logic [DATA_W-1:0] ub_rd_data_2_in,
    output logic [DATA_W-1:0] sys_data_1_out,
    output logic [DATA_W-1:0] sys_data_2_out,
    output logic              sys_valid_1_out,
    output logic              sys_valid_2_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out
);

    import ub_ctrl_pkg::*;

    localparam int EW = ADDR_W + 2;
    localparam logic [EW-1:0] LAST = EW'(UNIFIED_BUFFER_WIDTH - 1);

    ub_rd_state_t state, state_n;

    logic [ADDR_W-1:0] base_q, base_n;
    logic [LEN_W-1:0]  rows_q, rows_n;
    logic [LEN_W-1:0]  row_q, row_n;
    logic              tp_q, tp_n;
    logic [1:0]        drain_q, drain_n;
    logic              rd_en_n, err_n;
    logic [ADDR_W-1:0] addr1_n, addr2_n;
    logic              rd_vld_q;
    logic [EW-1:0]     end_addr;

    function automatic logic [ADDR_W-1:0] lane_addr(
        input logic [ADDR_W-1:0] b,
        input logic [LEN_W-1:0]  n,
        input logic [LEN_W-1:0]  r,
        input logic              tp,
        input logic              second
    );
        // Column-major: lane 2 reads the second column, N entries further on.
        if (tp) begin
            return b + ADDR_W'(r) + (second ? ADDR_W'(n) : '0);
        end
        return b + ADDR_W'({r, 1'b0}) + ADDR_W'(second);
    endfunction

    assign end_addr = EW'(base_addr_in) + (EW'(num_rows_in) << 1) - EW'(1);

    always_comb begin
        state_n = state;
        base_n  = base_q;
        rows_n  = rows_q;
        row_n   = row_q;
        tp_n    = tp_q;
        drain_n = drain_q;
        rd_en_n = 1'b0;
        addr1_n = '0;
        addr2_n = '0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_in) begin
                    base_n  = base_addr_in;
                    rows_n  = num_rows_in;
                    tp_n    = transpose_in;
                    row_n   = '0;
                    drain_n = '0;
                    if (num_rows_in == '0) begin
                        state_n = DONE;
                    end else if (end_addr > LAST) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = ISSUE;
                        rd_en_n = 1'b1;
                        addr1_n = lane_addr(base_addr_in, num_rows_in,
                                            '0, transpose_in, 1'b0);
                        addr2_n = lane_addr(base_addr_in, num_rows_in,
                                            '0, transpose_in, 1'b1);
                    end
                end
            end
            ISSUE: begin
                if (row_q == rows_q - LEN_W'(1)) begin
                    state_n = DRAIN;
                end else begin
                    row_n   = row_q + LEN_W'(1);
                    rd_en_n = 1'b1;
                    addr1_n = lane_addr(base_q, rows_q, row_n, tp_q, 1'b0);
                    addr2_n = lane_addr(base_q, rows_q, row_n, tp_q, 1'b1);
                end
            end
            DRAIN: begin
                // Three cycles cover UB latency, lane-1 and lane-2 stages.
                if (drain_q == 2'd2) begin
                    state_n = DONE;
                end else begin
                    drain_n = drain_q + 2'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            base_q           <= '0;
            rows_q           <= '0;
            row_q            <= '0;
            tp_q             <= 1'b0;
            drain_q          <= '0;
            ub_rd_en_out     <= 1'b0;
            ub_rd_addr_1_out <= '0;
            ub_rd_addr_2_out <= '0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
            err_out          <= 1'b0;
            rd_vld_q         <= 1'b0;
        end else begin
            state            <= state_n;
            base_q           <= base_n;
            rows_q           <= rows_n;
            row_q            <= row_n;
            tp_q             <= tp_n;
            drain_q          <= drain_n;
            ub_rd_en_out     <= rd_en_n;
            ub_rd_addr_1_out <= addr1_n;
            ub_rd_addr_2_out <= addr2_n;
            busy_out         <= (state_n == ISSUE) || (state_n == DRAIN);
            done_out         <= (state_n == DONE);
            err_out          <= err_n;
            rd_vld_q         <= ub_rd_en_out;
        end
    end

    lane_skew_reg #(
        .DEPTH(1),
        .WIDTH(DATA_W)
    ) u_lane1 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (ub_rd_data_1_in),
        .valid_in (rd_vld_q),
        .data_out (sys_data_1_out),
        .valid_out(sys_valid_1_out)
    );

    lane_skew_reg #(
        .DEPTH(1 + LANE2_SKEW),
        .WIDTH(DATA_W)
    ) u_lane2 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (ub_rd_data_2_in),
        .valid_in (rd_vld_q),
        .data_out (sys_data_2_out),
        .valid_out(sys_valid_2_out)
    );

endmodule

// File: doc/ub_read_controller.md
Name: ub_read_controller

Overview:
Sequences reads of the unified buffer into the two input lanes of the 2-wide systolic array. It accepts a start command with a base address, a row count and a transpose flag, then issues one dual-port UB read per cycle. Returned data is delivered with a one-cycle stagger between lane 1 and lane 2, giving the diagonal skew the array requires. It sits between the host/command sequencer, the UB read ports and the systolic array's left-edge inputs.

Parameters:
UNIFIED_BUFFER_WIDTH, 50, number of 16-bit UB entries; used for bounds checking
ADDR_W, 9, UB address width
LEN_W, 8, row-count width
DATA_W, 16, element width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start_in  in  1  command strobe; sampled only in IDLE
base_addr_in  in  ADDR_W  first UB address of the 2xN operand
num_rows_in  in  LEN_W  rows N to stream
transpose_in  in  1  0 = row-major, 1 = column-major operand
ub_rd_en_out  out  1  UB read strobe
ub_rd_addr_1_out  out  ADDR_W  lane-1 read address
ub_rd_addr_2_out  out  ADDR_W  lane-2 read address
ub_rd_data_1_in  in  DATA_W  lane-1 read data, valid 1 cycle after ub_rd_en_out
ub_rd_data_2_in  in  DATA_W  lane-2 read data, valid 1 cycle after ub_rd_en_out
sys_data_1_out  out  DATA_W  lane-1 element to the array
sys_data_2_out  out  DATA_W  lane-2 element to the array
sys_valid_1_out  out  1  lane-1 valid
sys_valid_2_out  out  1  lane-2 valid
busy_out  out  1  command in progress
done_out  out  1  one-cycle completion pulse
err_out  out  1  one-cycle bounds-error pulse

Behaviour:
- Reset: all outputs 0, state IDLE, counters and latched command cleared.
- Reset mid-operation aborts immediately. No done_out is produced, and the first clock after release is IDLE.
- States: IDLE, ISSUE, DRAIN, DONE. All outputs are registered.
- Command acceptance (start_in high in IDLE, cycle S):
  - Latch base, N and transpose.
  - Compute end = base + 2N - 1 at ADDR_W+2 bits, with no wrap.
  - If N = 0: done_out = 1 at S+1, no reads, then IDLE.
  - If end > UNIFIED_BUFFER_WIDTH-1: err_out = 1 at S+1, no reads, then IDLE.
  - Otherwise: go to ISSUE. busy_out goes high at S+1.
- start_in outside IDLE (ISSUE, DRAIN, DONE) is ignored.
- ISSUE: row r = 0..N-1 is issued at cycle S+1+r with ub_rd_en_out = 1.
  - Row-major: addr1 = base + 2r, addr2 = base + 2r + 1.
  - Transpose: addr1 = base + r, addr2 = base + N + r.
  - After row N-1 is issued, go to DRAIN. ub_rd_en_out = 0 and both addresses return to 0.
- Datapath for row r:
  - Read data arrives at S+2+r.
  - sys_data_1_out/sys_valid_1_out are registered at S+3+r.
  - sys_data_2_out/sys_valid_2_out are delayed one more cycle, at S+4+r.
  - Lane-2 skew is exactly 1 cycle. Data outputs are 0 whenever the matching valid is 0.
- DRAIN: wait until the last lane-2 output (S+N+3) has been presented, then go to DONE.
- DONE: done_out = 1 and busy_out = 0 at S+N+4, for one cycle, then IDLE. A new start is accepted from S+N+5.
- busy_out is high from S+1 through S+N+3 inclusive.
- err_out and done_out are never high in the same cycle.

Decomposition:
- Package ub_ctrl_pkg holds:
  - the state enum ub_rd_state_t {IDLE, ISSUE, DRAIN, DONE};
  - localparams DATA_W = 16 and ADDR_W = 9;
  - the lane skew constant LANE2_SKEW = 1.
- One sub-module, lane_skew_reg: a parameterized-depth data+valid delay line, asynchronous reset to 0. Instantiated with depth 1 for lane 1 and depth 2 for lane 2.
- Address generation, counters and the FSM stay in ub_read_controller.

Test Plan:
1. Row-major: UB model mem[0..5] = 1..6, start base=0, N=3, transpose=0 at S -> ub_rd_en_out high S+1..S+3 with addr pairs (0,1),(2,3),(4,5); lane1 = 1,3,5 at S+3..S+5; lane2 = 2,4,6 at S+4..S+6; done_out at S+7; busy_out high S+1..S+6.
2. Transpose: mem[4..9] = 10..15, base=4, N=3, transpose=1 -> addr pairs (4,7),(5,8),(6,9); lane1 = 10,11,12 at S+3..S+5; lane2 = 13,14,15 at S+4..S+6.
3. Zero length: N=0 -> done_out pulse at S+1; ub_rd_en_out, busy_out and valids stay 0.
4. Bounds: base=45, N=3 (end = 50) -> err_out at S+1, no read strobe; then base=44, N=3 (end = 49) completes normally with done_out at S+7.
5. Busy start: second start (base=10, N=1) at S+2 during a N=4 run -> ignored; exactly 4 reads occur, one done_out.
6. Reset mid-run: assert rst at S+2 of a N=4 run -> all outputs 0 at once, no done_out; after release a fresh N=1 command completes with done_out at S'+5.
